// File: rtl/obstacle_wave_scheduler.sv
// Lane-pattern sequencer, step pacing, scoring and collision handling.
// Optional score counter enabled by defining OBST_SCHED_SCORE_EN.
module obstacle_wave_scheduler #(
    parameter logic [7:0] LFSR_SEED       = 8'hA5,
    parameter int         BASE_DIV        = 8,
    parameter int         WAVES_PER_LEVEL = 4,
    parameter int         HIT_TICKS       = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic        wave_done,
    input  logic        on_collision,
    input  logic [1:0]  car_lane,
    output logic [3:0]  lane_en,
    output logic        step,
    output logic        game_over,
    output logic [2:0]  level,
    output logic [15:0] score
);

    localparam logic [7:0]  BD  = 8'(BASE_DIV);
    localparam logic [7:0]  WPL = 8'(WAVES_PER_LEVEL);
    localparam logic [15:0] HT  = 16'(HIT_TICKS);

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        RUN,
        HIT,
        OVER
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d, lfsr_nx;
    logic [7:0]  div_q, div_d, reload;
    logic [7:0]  wave_q, wave_d;
    logic [15:0] hit_q, hit_d;
    logic [3:0]  lane_q, lane_d;
    logic [3:0]  pat_q, pat_d;
    logic [2:0]  level_q, level_d;
    logic        step_q, step_d;
    logic        over_q, over_d;
    logic        wd_q, wd_rise;
`ifdef OBST_SCHED_SCORE_EN
    logic [15:0] score_q, score_d;
`endif

    // Guarantee at least one free lane and at least one obstacle.
    function automatic logic [3:0] fix(input logic [3:0] p);
        if (p == 4'b1111) return 4'b0111;
        if (p == 4'b0000) return 4'b0001;
        return p;
    endfunction

    assign lfsr_nx = {lfsr_q[6:0],
                      lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign wd_rise = wave_done & ~wd_q;

    always_comb begin
        if (BD > ({5'd0, level_q} + 8'd1)) reload = BD - {5'd0, level_q};
        else reload = 8'd1;
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        div_d   = div_q;
        wave_d  = wave_q;
        hit_d   = hit_q;
        lane_d  = lane_q;
        pat_d   = pat_q;
        level_d = level_q;
        step_d  = 1'b0;
`ifdef OBST_SCHED_SCORE_EN
        score_d = score_q;
`endif
        unique case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d = SPAWN;
                    level_d = 3'd0;
                    wave_d  = 8'd0;
                    div_d   = 8'd0;
`ifdef OBST_SCHED_SCORE_EN
                    score_d = 16'd0;
`endif
                end
            end
            SPAWN: begin
                lfsr_d  = lfsr_nx;
                lane_d  = fix(lfsr_nx[3:0]);
                div_d   = 8'd0;
                state_d = RUN;
            end
            RUN: begin
                if (on_collision && lane_q[car_lane]) begin
                    state_d = HIT;
                    pat_d   = lane_q;
                    hit_d   = 16'd0;
                end else begin
                    if (tick) begin
                        if (div_q == reload - 8'd1) begin
                            step_d = 1'b1;
                            div_d  = 8'd0;
                        end else begin
                            div_d = div_q + 8'd1;
                        end
                    end
                    if (wd_rise) begin
`ifdef OBST_SCHED_SCORE_EN
                        if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
`endif
                        if (wave_q + 8'd1 >= WPL) begin
                            wave_d = 8'd0;
                            if (level_q != 3'd7) level_d = level_q + 3'd1;
                        end else begin
                            wave_d = wave_q + 8'd1;
                        end
                        state_d = SPAWN;
                    end
                end
            end
            HIT: begin
                if (tick) begin
                    hit_d = hit_q + 16'd1;
                    // Blink: first 8 ticks dark, next 8 lit, and so on.
                    if (hit_d >= HT) begin
                        lane_d  = pat_q;
                        state_d = OVER;
                    end else begin
                        lane_d = hit_q[3] ? pat_q : 4'b0000;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        over_d = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            div_q   <= 8'd0;
            wave_q  <= 8'd0;
            hit_q   <= 16'd0;
            lane_q  <= 4'd0;
            pat_q   <= 4'd0;
            level_q <= 3'd0;
            step_q  <= 1'b0;
            over_q  <= 1'b0;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            div_q   <= div_d;
            wave_q  <= wave_d;
            hit_q   <= hit_d;
            lane_q  <= lane_d;
            pat_q   <= pat_d;
            level_q <= level_d;
            step_q  <= step_d;
            over_q  <= over_d;
            wd_q    <= wave_done;
        end
    end

`ifdef OBST_SCHED_SCORE_EN
    always_ff @(posedge clk) begin
        if (reset) score_q <= 16'd0;
        else score_q <= score_d;
    end
    assign score = score_q;
`else
    assign score = 16'h0000;
`endif

    assign lane_en   = lane_q;
    assign step      = step_q;
    assign game_over = over_q;
    assign level     = level_q;

endmodule
